narrow_32to16: RTL
==================

NARROW_32TO16 -- requirements
Module: narrow_32to16

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: upstream offers a 32-bit word.
REQ-004 The block SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-005 The block SHALL have port in_data, input, 32 bits: word to narrow.
REQ-006 The block SHALL have port in_half, input, 1 bit: 1 = emit low halfword only; 0 = emit low then high.
REQ-007 The block SHALL have port out_valid, output, 1 bit: halfword presented downstream.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream takes the halfword this cycle.
REQ-009 The block SHALL have port out_data, output, 16 bits: halfword.
REQ-010 The block SHALL have port out_last, output, 1 bit: current halfword is the final one of its word.
REQ-011 The block SHALL have port err_clr, input, 1 bit: synchronous clear of trunc_err.
REQ-012 The block SHALL have port trunc_err, output, 1 bit: sticky lossy-narrowing flag.
REQ-013 The block SHALL have port word_cnt, output, 8 bits: count of fully emitted words.

Function
REQ-014 The block SHALL implement an FSM with exactly the states IDLE, LO, HI, a 32-bit hold register and a 1-bit half register.
REQ-015 In IDLE, the block SHALL drive in_ready=1 and out_valid=0; an accept (in_valid & in_ready) SHALL capture in_data and in_half and move the FSM to LO.
REQ-016 In LO, the block SHALL drive out_valid=1, out_data=hold[15:0] and out_last=half.
REQ-017 In LO with out_ready=1: if half=0, the FSM SHALL move to HI; if half=1, the word SHALL complete.
REQ-018 In HI, the block SHALL drive out_valid=1, out_data=hold[31:16] and out_last=1; with out_ready=1, the word SHALL complete.
REQ-019 At word completion, the block SHALL drive in_ready=1 in that cycle (combinational from out_ready); if in_valid=1, the new word SHALL be captured and the FSM SHALL go to LO (back-to-back, no bubble); otherwise the FSM SHALL go to IDLE.
REQ-020 In LO or HI, the block SHALL drive in_ready=0 whenever the word does not complete that cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable, and the state SHALL not change.
REQ-022 When out_valid=0, the block SHALL drive out_data=16'h0000 and out_last=0.
REQ-023 Latency SHALL be one cycle from accept to the first out_valid; sustained throughput SHALL be 1 halfword per cycle.
REQ-024 An accept with in_half=1 and in_data[31:16]!=0 SHALL set trunc_err on the next edge.
REQ-025 err_clr=1 SHALL clear trunc_err; when a set and err_clr coincide, set SHALL win.
REQ-026 word_cnt SHALL increment by 1 at each word completion and wrap 8'hFF -> 8'h00.
REQ-027 in_data and in_half SHALL be ignored when no accept occurs.

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, hold=0, half=0, trunc_err=0, word_cnt=0, out_valid=0, out_data=0, out_last=0, in_ready=1 (in_ready=1 is a combinational consequence of IDLE).
REQ-029 Reset asserted mid-word SHALL discard the pending halves, which SHALL never be emitted.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Full word, out_ready=1: accept 32'hDEAD_BEEF, in_half=0 -> out 16'hBEEF (last=0), then 16'hDEAD (last=1); word_cnt=1.
REQ-032 Half mode, lossless: accept 32'h0000_1234, in_half=1 -> single out 16'h1234 with last=1; trunc_err stays 0.
REQ-033 Half mode, lossy: accept 32'h0001_0002, in_half=1 -> out 16'h0002 last=1, trunc_err=1; err_clr pulse -> 0; err_clr coincident with a new lossy accept -> trunc_err stays 1.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HI of 32'hCAFE_F00D -> out_data holds 16'hCAFE and in_ready=0; release -> completes; a waiting word is accepted in the same cycle with no bubble.
REQ-035 Streaming plus wrap: 256 back-to-back half-mode words -> 1 halfword/cycle, word_cnt returns to 8'h00.
REQ-036 Reset in LO of 32'h1111_2222 -> outputs zero immediately; after release, 16'h1111 is never emitted and the next word is emitted correctly.

Source files
------------

// File: rtl/narrow_32to16.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_32to16
//  Description : Splits 32-bit words into 16-bit halfwords (low half first).
//                In half mode only the low halfword is emitted, and a nonzero
//                high half discarded this way raises a sticky trunc_err.
//                Counts completed words. Valid/ready on both sides, with
//                back-to-back word acceptance on the completing beat.
//  Revision    : 1.0  initial release
// ============================================================================
module narrow_32to16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_half,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        err_clr,
    output logic        trunc_err,
    output logic [7:0]  word_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_hold;
    logic        r_half;
    logic        r_trunc_err;
    logic [7:0]  r_word_cnt;

    logic        w_complete;
    logic        w_accept;
    logic        w_trunc_set;

    // Word finishes when its final halfword is taken by downstream.
    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            LO:      w_complete = out_ready & r_half;
            HI:      w_complete = out_ready;
            default: w_complete = 1'b0;
        endcase
    end

    // Ready when empty, or when the last halfword leaves this cycle.
    assign in_ready    = (r_state == IDLE) | w_complete;
    assign w_accept    = in_valid & in_ready;
    assign w_trunc_set = w_accept & in_half & (|in_data[31:16]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a stalled halfword keeps the current state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = LO;
                end
            end
            LO: begin
                if (out_ready) begin
                    if (!r_half) begin
                        w_state_next = HI;
                    end else if (w_accept) begin
                        w_state_next = LO;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            HI: begin
                if (out_ready) begin
                    w_state_next = w_accept ? LO : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the word and its mode only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 32'h0000_0000;
            r_half <= 1'b0;
        end else if (w_accept) begin
            r_hold <= in_data;
            r_half <= in_half;
        end
    end

    // Sticky truncation flag; a new set takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trunc_err <= 1'b0;
        end else if (w_trunc_set) begin
            r_trunc_err <= 1'b1;
        end else if (err_clr) begin
            r_trunc_err <= 1'b0;
        end
    end

    // Completed-word counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= 8'h00;
        end else if (w_complete) begin
            r_word_cnt <= r_word_cnt + 8'h01;
        end
    end

    // Output halfword selection; zeros whenever nothing is presented.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_last  = 1'b0;
        case (r_state)
            LO: begin
                out_valid = 1'b1;
                out_data  = r_hold[15:0];
                out_last  = r_half;
            end
            HI: begin
                out_valid = 1'b1;
                out_data  = r_hold[31:16];
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 16'h0000;
                out_last  = 1'b0;
            end
        endcase
    end

    assign trunc_err = r_trunc_err;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire
